// File: rtl/merge_switch_if.sv
// Handshake bundle between the two upstream requesters, the downstream
// ready and the merge switch controller.
interface merge_switch_if;
   logic [1:0] i_req;          // per-requester valid, bit0 = low, bit1 = high
   logic [1:0] i_last;         // per-requester end-of-packet, qualified by i_req
   logic       i_ready;        // downstream accepts a beat this cycle
   logic [1:0] o_grant;        // per-requester ready, one-hot or zero
   logic       o_en;           // merge switch enable
   logic [1:0] o_cmd;          // 2'b01 route low, 2'b10 route high, 2'b00 none
   logic       o_last_served;  // index of the most recent owner
   logic       o_err;          // sticky watchdog-fired flag

   // Requester / downstream side
   modport master (
      output i_req,
      output i_last,
      output i_ready,
      input  o_grant,
      input  o_en,
      input  o_cmd,
      input  o_last_served,
      input  o_err
   );

   // Controller side
   modport slave (
      input  i_req,
      input  i_last,
      input  i_ready,
      output o_grant,
      output o_en,
      output o_cmd,
      output o_last_served,
      output o_err
   );
endinterface

// File: rtl/merge_switch_ctrl.sv
// Packet-level arbiter and sequencer for a 2-input merge switch.
// One requester owns the switch at a time until its packet ends; ties are
// broken in favour of the input that was not served last. A watchdog takes
// the switch back from an owner that drops its request mid-packet and
// leaves a sticky error flag behind.
module merge_switch_ctrl #(
   parameter int TIMEOUT   = 64,  // stalled cycles tolerated before forced release (>= 2)
   parameter int CNT_WIDTH = 7    // 2**CNT_WIDTH must exceed TIMEOUT
) (
   input  logic          clk,
   input  logic          rst,
   merge_switch_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      OWN_LOW  = 2'b01,
      OWN_HIGH = 2'b10
   } state_t;

   // Last counter value before the watchdog fires on the next stalled cycle.
   localparam logic [CNT_WIDTH-1:0] WD_LIMIT = CNT_WIDTH'(TIMEOUT - 1);

   // Switch command that routes the given input index.
   function automatic logic [1:0] route_cmd(input logic idx);
      logic [1:0] cmd;
      if (idx) begin
         cmd = 2'b10;
      end else begin
         cmd = 2'b01;
      end
      return cmd;
   endfunction

   // Ownership state that corresponds to the given input index.
   function automatic state_t own_state(input logic idx);
      state_t st;
      if (idx) begin
         st = OWN_HIGH;
      end else begin
         st = OWN_LOW;
      end
      return st;
   endfunction

   state_t                 state_r;
   logic                   last_served_r;
   logic [CNT_WIDTH-1:0]   cnt_r;
   logic                   err_r;

   logic                   own_idx_s;    // index of the current owner (valid when owning)
   logic                   own_req_s;    // owner's request
   logic                   oth_req_s;    // the other input's request
   logic                   rel_beat_s;   // owner's last beat accepted this cycle
   logic                   wd_fire_s;    // owner stalled long enough to be evicted
   logic                   idle_pick_s;  // winner when leaving IDLE
   logic                   idle_go_s;    // some input requests while IDLE

   // Decode the owner's handshake view and the arbitration winner.
   always_comb begin
      own_idx_s   = 1'b0;
      own_req_s   = 1'b0;
      oth_req_s   = 1'b0;
      rel_beat_s  = 1'b0;
      wd_fire_s   = 1'b0;
      idle_pick_s = 1'b0;
      idle_go_s   = 1'b0;
      case (state_r)
         OWN_LOW: begin
            own_idx_s  = 1'b0;
            own_req_s  = bus.i_req[0];
            oth_req_s  = bus.i_req[1];
            rel_beat_s = bus.i_req[0] & bus.i_ready & bus.i_last[0];
         end
         OWN_HIGH: begin
            own_idx_s  = 1'b1;
            own_req_s  = bus.i_req[1];
            oth_req_s  = bus.i_req[0];
            rel_beat_s = bus.i_req[1] & bus.i_ready & bus.i_last[1];
         end
         IDLE: begin
            own_idx_s = 1'b0;
         end
         default: begin
            own_idx_s = 1'b0;
         end
      endcase

      // The watchdog only fires while someone owns the switch.
      if ((state_r != IDLE) && !own_req_s && (cnt_r == WD_LIMIT)) begin
         wd_fire_s = 1'b1;
      end else begin
         wd_fire_s = 1'b0;
      end

      // Single requester wins outright; a tie goes to the input not served last.
      case (bus.i_req)
         2'b01: begin
            idle_pick_s = 1'b0;
            idle_go_s   = 1'b1;
         end
         2'b10: begin
            idle_pick_s = 1'b1;
            idle_go_s   = 1'b1;
         end
         2'b11: begin
            idle_pick_s = ~last_served_r;
            idle_go_s   = 1'b1;
         end
         default: begin
            idle_pick_s = 1'b0;
            idle_go_s   = 1'b0;
         end
      endcase
   end

   // Ownership FSM, last-served history, watchdog counter and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         last_served_r <= 1'b1;
         cnt_r         <= {CNT_WIDTH{1'b0}};
         err_r         <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               cnt_r <= {CNT_WIDTH{1'b0}};
               if (idle_go_s) begin
                  state_r       <= own_state(idle_pick_s);
                  last_served_r <= idle_pick_s;
               end else begin
                  state_r <= IDLE;
               end
            end
            OWN_LOW, OWN_HIGH: begin
               if (rel_beat_s) begin
                  // Packet done: hand over without a bubble if the other side waits.
                  cnt_r <= {CNT_WIDTH{1'b0}};
                  if (oth_req_s) begin
                     state_r       <= own_state(~own_idx_s);
                     last_served_r <= ~own_idx_s;
                  end else if (own_req_s) begin
                     state_r <= state_r;
                  end else begin
                     state_r <= IDLE;
                  end
               end else if (own_req_s) begin
                  // Active or backpressured owner is not stalling.
                  cnt_r   <= {CNT_WIDTH{1'b0}};
                  state_r <= state_r;
               end else if (wd_fire_s) begin
                  cnt_r   <= {CNT_WIDTH{1'b0}};
                  state_r <= IDLE;
                  err_r   <= 1'b1;
               end else begin
                  cnt_r   <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                  state_r <= state_r;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= {CNT_WIDTH{1'b0}};
            end
         endcase
      end
   end

   // Switch controls follow the owner; grants pass the downstream ready through.
   always_comb begin
      bus.o_en    = 1'b0;
      bus.o_cmd   = 2'b00;
      bus.o_grant = 2'b00;
      case (state_r)
         OWN_LOW: begin
            bus.o_en    = 1'b1;
            bus.o_cmd   = route_cmd(1'b0);
            bus.o_grant = {1'b0, bus.i_ready};
         end
         OWN_HIGH: begin
            bus.o_en    = 1'b1;
            bus.o_cmd   = route_cmd(1'b1);
            bus.o_grant = {bus.i_ready, 1'b0};
         end
         IDLE: begin
            bus.o_en    = 1'b0;
            bus.o_cmd   = 2'b00;
            bus.o_grant = 2'b00;
         end
         default: begin
            bus.o_en    = 1'b0;
            bus.o_cmd   = 2'b00;
            bus.o_grant = 2'b00;
         end
      endcase
   end

   assign bus.o_last_served = last_served_r;
   assign bus.o_err         = err_r;

endmodule
